// File: rtl/reg_status_file_if.sv
// Operand-lookup / commit / rename bus for reg_status_file.
//   cdb_*        : in-order commit from the reorder buffer (tag, rd, value)
//   rename_*     : dispatch marks rd as pending on a ROB tag
//   predict_fail : branch-mispredict flush of all pending tags
//   rs*_idx      : operand lookup indices
//   rs*_val/tag  : operand values; the value is valid when the tag is 0
// Modport slave is the register file; modport master is the pipeline driving it.
interface reg_status_file_if;
    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [4:0]  cdb_rd_idx;
    logic [31:0] cdb_val;
    logic        rename_valid;
    logic [4:0]  rename_rd_idx;
    logic [3:0]  rename_tag;
    logic        predict_fail;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;

    modport master (
        output cdb_active, cdb_tag, cdb_rd_idx, cdb_val,
        output rename_valid, rename_rd_idx, rename_tag, predict_fail,
        output rs1_idx, rs2_idx,
        input  rs1_val, rs2_val, rs1_tag, rs2_tag
    );

    modport slave (
        input  cdb_active, cdb_tag, cdb_rd_idx, cdb_val,
        input  rename_valid, rename_rd_idx, rename_tag, predict_fail,
        input  rs1_idx, rs2_idx,
        output rs1_val, rs2_val, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (pending ROB tag).
// Ports:
//   clk_in : clock, all state updates on the rising edge
//   rst_in : asynchronous active-low reset, clears all values and tags
//   rdy_in : when low, all state is held (reads still work)
//   bus    : reg_status_file_if.slave (commit, rename, flush, two read ports)
// Reads are combinational with a commit bypass; x0 always reads 0 / tag 0.
module reg_status_file (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    reg_status_file_if.slave   bus
);

    logic [31:0] vals_q [32];
    logic [31:0] vals_d [32];
    logic [3:0]  tags_q [32];
    logic [3:0]  tags_d [32];

    logic commit_en;
    logic rename_en;

    assign commit_en = bus.cdb_active && (bus.cdb_rd_idx != 5'd0);
    // rename_tag 0 would mean "ready", so it is treated as no rename at all
    assign rename_en = bus.rename_valid && (bus.rename_rd_idx != 5'd0) &&
                       (bus.rename_tag != 4'd0);

    // Next state: commit first, then flush or rename overrides the tag so a
    // same-cycle rename of the committed rd leaves the younger tag in place.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            vals_d[i] = vals_q[i];
            tags_d[i] = tags_q[i];
        end
        if (rdy_in) begin
            if (commit_en) begin
                vals_d[bus.cdb_rd_idx] = bus.cdb_val;
                // A mismatching tag belongs to a younger rename still in flight
                if (tags_q[bus.cdb_rd_idx] == bus.cdb_tag) begin
                    tags_d[bus.cdb_rd_idx] = 4'd0;
                end
            end
            if (bus.predict_fail) begin
                for (int i = 0; i < 32; i++) begin
                    tags_d[i] = 4'd0;
                end
            end else if (rename_en) begin
                tags_d[bus.rename_rd_idx] = bus.rename_tag;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                vals_q[i] <= 32'd0;
                tags_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                vals_q[i] <= vals_d[i];
                tags_q[i] <= tags_d[i];
            end
        end
    end

    // Read port 1: a commit whose tag matches the pending producer is forwarded.
    // Same-cycle renames are deliberately invisible until the next cycle.
    always_comb begin
        bus.rs1_val = 32'd0;
        bus.rs1_tag = 4'd0;
        if (bus.rs1_idx != 5'd0) begin
            if (bus.cdb_active && (bus.cdb_rd_idx == bus.rs1_idx) &&
                (tags_q[bus.rs1_idx] == bus.cdb_tag)) begin
                bus.rs1_val = bus.cdb_val;
            end else begin
                bus.rs1_val = vals_q[bus.rs1_idx];
                bus.rs1_tag = tags_q[bus.rs1_idx];
            end
        end
    end

    // Read port 2: same forwarding rule as port 1
    always_comb begin
        bus.rs2_val = 32'd0;
        bus.rs2_tag = 4'd0;
        if (bus.rs2_idx != 5'd0) begin
            if (bus.cdb_active && (bus.cdb_rd_idx == bus.rs2_idx) &&
                (tags_q[bus.rs2_idx] == bus.cdb_tag)) begin
                bus.rs2_val = bus.cdb_val;
            end else begin
                bus.rs2_val = vals_q[bus.rs2_idx];
                bus.rs2_tag = tags_q[bus.rs2_idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
module tb_reg_status_file;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    reg_status_file_if bus ();

    reg_status_file dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        ca;
        logic [3:0]  ctag;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic        rv;
        logic [4:0]  rrd;
        logic [3:0]  rtag;
        logic        pf;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1v;
        logic [3:0]  e1t;
        logic [31:0] e2v;
        logic [3:0]  e2t;
    } vec_t;

    vec_t vecs[$];
    int checks;
    int failures;

    task automatic add(input logic rdy, input logic ca, input logic [3:0] ctag,
                       input logic [4:0] crd, input logic [31:0] cval,
                       input logic rv, input logic [4:0] rrd, input logic [3:0] rtag,
                       input logic pf, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] e1v, input logic [3:0] e1t,
                       input logic [31:0] e2v, input logic [3:0] e2t);
        vec_t v;
        v = '{rdy, ca, ctag, crd, cval, rv, rrd, rtag, pf, rs1, rs2, e1v, e1t, e2v, e2t};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rdy_in            = v.rdy;
        bus.cdb_active    = v.ca;
        bus.cdb_tag       = v.ctag;
        bus.cdb_rd_idx    = v.crd;
        bus.cdb_val       = v.cval;
        bus.rename_valid  = v.rv;
        bus.rename_rd_idx = v.rrd;
        bus.rename_tag    = v.rtag;
        bus.predict_fail  = v.pf;
        bus.rs1_idx       = v.rs1;
        bus.rs2_idx       = v.rs2;
    endtask

    task automatic check_all(input string name, input logic [31:0] e1v, input logic [3:0] e1t,
                             input logic [31:0] e2v, input logic [3:0] e2t);
        check({name, ".rs1_val"}, bus.rs1_val, e1v);
        check({name, ".rs1_tag"}, {28'd0, bus.rs1_tag}, {28'd0, e1t});
        check({name, ".rs2_val"}, bus.rs2_val, e2v);
        check({name, ".rs2_tag"}, {28'd0, bus.rs2_tag}, {28'd0, e2t});
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        vec_t v;
        v = '{1'b1, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 1'b0, rs1, rs2,
              32'd0, 4'd0, 32'd0, 4'd0};
        drive(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //   rdy ca ctag crd cval          rv rrd rtag pf rs1 rs2  e1v           e1t e2v           e2t
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 5,  0,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 5,  3, 0, 5,  0,  32'h0,        0, 32'h0,        0);
        add(1, 1, 3, 5,  32'hDEADBEEF, 0, 0,  0, 0, 5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 5,  0,  32'hDEADBEEF, 0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 7,  2, 0, 7,  0,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 7,  4, 0, 7,  0,  32'h0,        2, 32'h0,        0);
        add(1, 1, 2, 7,  32'h11,       0, 0,  0, 0, 7,  0,  32'h0,        4, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 7,  5,  32'h11,       4, 32'hDEADBEEF, 0);
        add(1, 0, 0, 0,  32'h0,        1, 9,  6, 0, 0,  9,  32'h0,        0, 32'h0,        0);
        add(1, 1, 6, 9,  32'h55,       0, 0,  0, 0, 9,  9,  32'h55,       0, 32'h55,       0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 9,  0,  32'h55,       0, 32'h0,        0);
        add(1, 1, 5, 0,  32'h1234,     1, 0,  5, 0, 0,  0,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 0,  0,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 1,  1, 0, 1,  0,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 2,  2, 0, 1,  0,  32'h0,        1, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        1, 3,  3, 0, 2,  1,  32'h0,        2, 32'h0,        1);
        add(1, 0, 0, 0,  32'h0,        1, 4,  5, 0, 3,  0,  32'h0,        3, 32'h0,        0);
        // flush with a rename (ignored) and a commit (value still written)
        add(1, 1, 2, 2,  32'h22,       1, 8,  1, 1, 4,  8,  32'h0,        5, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 4,  8,  32'h0,        0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 2,  1,  32'h22,       0, 32'h0,        0);
        // same-cycle commit and rename of the same rd
        add(1, 0, 0, 0,  32'h0,        1, 10, 7, 0, 10, 3,  32'h0,        0, 32'h0,        0);
        add(1, 1, 7, 10, 32'hA5,       1, 10, 8, 0, 10, 0,  32'hA5,       0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 10, 0,  32'hA5,       8, 32'h0,        0);
        // rename_tag 0 is a no-op
        add(1, 0, 0, 0,  32'h0,        1, 10, 0, 0, 10, 0,  32'hA5,       8, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 10, 0,  32'hA5,       8, 32'h0,        0);
        // rdy low: bypass still visible, no state change
        add(0, 1, 8, 10, 32'hBB,       1, 11, 9, 0, 10, 11, 32'hBB,       0, 32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  0, 0, 10, 11, 32'hA5,       8, 32'h0,        0);

        rst_in = 1'b0;
        idle(5'd0, 5'd0);
        repeat (2) @(negedge clk_in);
        #1;
        check_all("reset_hold", 32'h0, 4'd0, 32'h0, 4'd0);
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_in);
            drive(vecs[i]);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e1v, vecs[i].e1t, vecs[i].e2v, vecs[i].e2t);
        end

        // Mid-cycle async reset with a commit pending: outputs clear before the edge
        @(negedge clk_in);
        idle(5'd10, 5'd5);
        #1;
        check_all("pre_reset", 32'hA5, 4'd8, 32'hDEADBEEF, 4'd0);
        bus.cdb_active = 1'b1;
        bus.cdb_tag    = 4'd8;
        bus.cdb_rd_idx = 5'd10;
        bus.cdb_val    = 32'h77;
        #1;
        rst_in = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 4'd0, 32'h0, 4'd0);
        @(posedge clk_in);
        #1;
        check_all("reset_no_commit", 32'h0, 4'd0, 32'h0, 4'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(5'd10, 5'd7);
        #1;
        check_all("post_reset", 32'h0, 4'd0, 32'h0, 4'd0);
        @(posedge clk_in);
        #1;
        check_all("post_reset_edge", 32'h0, 4'd0, 32'h0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port rdy_in, input, 1; when low, all state is held.
REQ-004 SHALL have ports cdb_active/cdb_tag/cdb_rd_idx/cdb_val, input, 1/4/5/32: the in-order commit from the reorder buffer.
REQ-005 SHALL have ports rename_valid/rename_rd_idx/rename_tag, input, 1/5/4: dispatch marks rd as pending on a ROB tag.
REQ-006 SHALL have port predict_fail, input, 1: flush from the branch predictor.
REQ-007 SHALL have ports rs1_idx/rs2_idx, input, 5/5: operand lookup indices.
REQ-008 SHALL have ports rs1_val/rs2_val, output, 32/32: operand values, valid when the matching tag output is 0.
REQ-009 SHALL have ports rs1_tag/rs2_tag, output, 4/4: pending producer ROB tag; 0 means the value is ready.

Function
REQ-010 SHALL hold 32 x 32-bit values and 32 x 4-bit tags; tag 0 = no pending producer.
REQ-011 SHALL keep x0 value 0 and tag 0 at all times; commits and renames to x0 are ignored.
REQ-012 SHALL produce read outputs combinationally in the same cycle as rs*_idx, with no register stage.
REQ-013 SHALL bypass on read: if cdb_active and cdb_rd_idx==rs_idx!=0 and the stored tag==cdb_tag, output cdb_val with tag 0.
REQ-014 SHALL bypass rename on read: if rename_valid and rename_rd_idx==rs_idx!=0, output the old value/tag; the new tag is not visible until the next cycle.
REQ-015 SHALL, on commit (cdb_active, rdy_in high), write cdb_val into reg[cdb_rd_idx] unconditionally for rd!=0.
REQ-016 SHALL clear tag[cdb_rd_idx] on commit only if it equals cdb_tag; a mismatch means a younger rename is pending and the tag is kept.
REQ-017 SHALL, on rename (rename_valid, rdy_in high, predict_fail low), set tag[rename_rd_idx] = rename_tag for rd!=0.
REQ-018 SHALL, on same-cycle commit and rename of the same rd, write the value and make the final tag rename_tag.
REQ-019 SHALL, on predict_fail, clear all 32 tags to 0, ignore any rename that cycle, and still perform that cycle's commit value write.
REQ-020 SHALL treat rename_tag==0 as a no-op rename.
REQ-021 SHALL, when rdy_in is low, update no state while read outputs still reflect the current state with bypass.
REQ-022 SHALL apply a single-cycle latency to all writes, visible on reads in the following cycle.

Reset
REQ-023 SHALL, while rst_in is low (async), set all values and tags to 0, independent of clk_in.
REQ-024 SHALL, after reset, return 0 on every read output (rs*_val=0, rs*_tag=0).
REQ-025 SHALL discard all pending tags when rst_in is asserted mid-operation, with no commit performed that cycle.

Verification
REQ-026 SHALL cover: rename x5 with tag 3, then commit tag 3 rd 5 val 0xDEADBEEF -> the next cycle rs1_idx=5 gives val 0xDEADBEEF, tag 0.
REQ-027 SHALL cover: rename x7 tag 2, then rename x7 tag 4, then commit tag 2 val 0x11 -> rs1 x7 gives tag 4, and val 0x11 is stored.
REQ-028 SHALL cover: x9 tag 6 pending, with commit tag 6 val 0x55 in the same cycle as reading rs2_idx=9 -> rs2_val=0x55, rs2_tag=0 combinationally.
REQ-029 SHALL cover: rename x0 tag 5 and commit rd 0 val 0x1234 -> rs1_idx=0 reads val 0, tag 0.
REQ-030 SHALL cover: tags pending on x1..x4 with predict_fail high and rename x8 tag 1 -> all tags 0, x8 tag 0.
REQ-031 SHALL cover: rdy_in low with a valid rename and commit -> no state change; rst_in low mid-cycle -> outputs 0 before the next edge.
